ripple_count_monitor: RTL and testbench
=======================================

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 Parameter TOTAL_W, default 16: width of the accumulated event total.
REQ-002 Parameter STABLE_CYC, default 2: consecutive equal synchronized samples required before a count value is accepted.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port count_in, input, [0:3]: free-running ripple counter value, asynchronous to clk; count_in[3] is the LSB, count_in[0] the MSB.
REQ-006 Port clear, input, 1: synchronous clear of total, overflow and pending delta; re-arms the baseline.
REQ-007 Port total, output, TOTAL_W: accumulated count events since reset or clear.
REQ-008 Port overflow, output, 1: sticky flag, total wrapped past 2^TOTAL_W-1.
REQ-009 Port delta_valid, output, 1: a pending nonzero delta is presented.
REQ-010 Port delta_ready, input, 1: consumer accepts delta when high with delta_valid.
REQ-011 Port delta, output, 5: events since the last accepted handshake, saturating at 31.
REQ-012 Port delta_lost, output, 1: sticky flag, pending delta saturated and events were dropped from delta (total remains exact).

Function
REQ-013 count_in SHALL pass through a two-flop synchronizer before any other use.
REQ-014 A synchronized value SHALL be accepted only after STABLE_CYC consecutive equal samples; transitional ripple values that change within that window SHALL be ignored.
REQ-015 FSM states SHALL be INIT (no baseline) and TRACK (baseline held).
- INIT -> TRACK on the first accepted value, which becomes the baseline; no delta or total change.
- TRACK -> INIT on clear.
REQ-016 In TRACK, each accepted value differing from the baseline SHALL produce step = (new - baseline) mod 16 (4-bit wrap, e.g. 14 -> 2 gives 4), and the baseline SHALL be updated to the new value.
REQ-017 total SHALL add step modulo 2^TOTAL_W in the cycle after acceptance; a carry out SHALL set overflow.
REQ-018 step SHALL be added to the pending delta, saturating at 31; saturation SHALL set delta_lost.
REQ-019 delta_valid SHALL be high whenever pending delta is nonzero; delta and delta_valid SHALL stay stable until the handshake completes.
REQ-020 On delta_valid & delta_ready, pending SHALL clear; if a step lands in the same cycle, pending SHALL become that step (not be lost) and delta_valid SHALL remain high.
REQ-021 clear SHALL take priority over every simultaneous step and handshake: total, overflow, delta_lost and pending go to 0, delta_valid deasserts next cycle, FSM enters INIT.
REQ-022 Latency from a stable count_in change to the total update SHALL be 2 (sync) + STABLE_CYC + 1 clk cycles.

Reset
REQ-023 While rst_n is low: total=0, overflow=0, delta=0, delta_valid=0, delta_lost=0, synchronizer and filter registers=0, FSM=INIT.
REQ-024 Release of rst_n SHALL behave identically to a clear; the first accepted value after reset is baseline only.

Structure
REQ-025 The FSM state encoding and the 16-count wrap constant SHALL live in the shared counter package alongside the ripple counter definitions.
REQ-026 The synchronizer plus stability filter SHALL be one sub-module, count_sync_filter, parameterized by width and STABLE_CYC.

Verification
REQ-027 Reset, hold count_in=5 for 10 cycles, then 9 -> total=4, delta=4 with delta_valid high until delta_ready.
REQ-028 Step count_in 14 -> 15 -> 0 -> 1 -> 2 with delta_ready held high -> total=4, four single-event handshakes, overflow=0.
REQ-029 Glitch count_in 7 -> 6 -> 4 -> 8 with each intermediate held one cycle, from baseline 7 -> only 8 accepted, total=1.
REQ-030 delta_ready low, 40 events in steps of 4 -> delta=31, delta_lost=1, total=40; then ready -> delta_valid low next cycle.
REQ-031 TOTAL_W=4, 17 events -> total=1, overflow=1; clear asserted together with a step -> total=0, overflow=0, FSM INIT, step discarded.
REQ-032 rst_n low mid-pending (delta=3) -> all outputs 0 immediately, no handshake after release until a new baseline plus change.

Source files
------------

// File: rtl/ripple_count_monitor_pkg.sv
// Shared ripple-counter definitions: counter width, 16-count wrap, delta sizing
// and the monitor FSM state encoding.
package ripple_count_monitor_pkg;

  localparam int RIPPLE_W = 4;
  localparam int DELTA_W  = 5;

  localparam logic [RIPPLE_W:0]  RIPPLE_WRAP = 5'd16;
  localparam logic [DELTA_W-1:0] DELTA_MAX   = 5'd31;

  typedef logic [RIPPLE_W-1:0] ripple_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // Forward distance from base to cur on the 4-bit counter wheel.
  function automatic ripple_t ripple_step(input ripple_t cur, input ripple_t base);
    logic [RIPPLE_W:0] diff;
    diff = {1'b0, cur} + RIPPLE_WRAP - {1'b0, base};
    return diff[RIPPLE_W-1:0];
  endfunction

endpackage

// File: rtl/ripple_count_monitor_sync.sv
// count_sync_filter: two-flop synchronizer followed by a stability filter that
// emits a one-cycle accept pulse after STABLE_CYC equal synchronized samples.
module count_sync_filter #(
  parameter int W          = 4,
  parameter int STABLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] count_async,
  output logic         acc_valid,
  output logic [W-1:0] acc_value
);
  import ripple_count_monitor_pkg::*;

  localparam int RUN_W = $clog2(STABLE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [W-1:0]     sync1_q, sync1_d;
  logic [W-1:0]     sync2_q, sync2_d;
  logic [1:0]       fill_q, fill_d;
  logic [W-1:0]     sample_q, sample_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             acc_valid_q, acc_valid_d;
  logic [W-1:0]     acc_value_q, acc_value_d;

  always_comb begin
    sync1_d     = count_async;
    sync2_d     = sync1_q;
    fill_d      = {fill_q[0], 1'b1};
    sample_d    = sample_q;
    run_d       = run_q;
    acc_valid_d = 1'b0;
    acc_value_d = acc_value_q;
    // Samples only count once the synchronizer holds real data, not reset zeros.
    if (fill_q[1]) begin
      if ((run_q == '0) || (sync2_q != sample_q)) begin
        sample_d    = sync2_q;
        run_d       = RUN_ONE;
        acc_valid_d = (RUN_ONE == RUN_MAX);
      end else if (run_q < RUN_MAX) begin
        run_d       = run_q + RUN_ONE;
        acc_valid_d = (run_d == RUN_MAX);
      end
      if (acc_valid_d) acc_value_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      fill_q      <= '0;
      sample_q    <= '0;
      run_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_value_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      fill_q      <= fill_d;
      sample_q    <= sample_d;
      run_q       <= run_d;
      acc_valid_q <= acc_valid_d;
      acc_value_q <= acc_value_d;
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_value = acc_value_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Ripple counter event monitor: turns filtered counter samples into an exact
// running total plus a saturating, handshaked delta.
//   state    | meaning
//   ST_INIT  | no baseline yet; next accepted value becomes the baseline
//   ST_TRACK | baseline held; accepted changes produce steps
module ripple_count_monitor #(
  parameter int TOTAL_W    = 16,
  parameter int STABLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [0:3]         count_in,
  input  logic               clear,
  output logic [TOTAL_W-1:0] total,
  output logic               overflow,
  output logic               delta_valid,
  input  logic               delta_ready,
  output logic [4:0]         delta,
  output logic               delta_lost
);
  import ripple_count_monitor_pkg::*;

  ripple_t    cnt_vec;
  logic       acc_valid;
  ripple_t    acc_value;

  mon_state_e         state_q, state_d;
  ripple_t            base_q, base_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               ovf_q, ovf_d;
  logic [DELTA_W-1:0] pend_q, pend_d;
  logic               lost_q, lost_d;

  ripple_t            step;
  logic               do_step;
  logic               hs;
  logic [DELTA_W-1:0] pend_base;
  logic [DELTA_W:0]   pend_sum;
  logic [TOTAL_W:0]   total_sum;

  // count_in[0] is the MSB, so a plain assignment keeps the numeric value.
  assign cnt_vec = count_in;

  count_sync_filter #(
    .W          (RIPPLE_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_async (cnt_vec),
    .acc_valid   (acc_valid),
    .acc_value   (acc_value)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    total_d   = total_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    lost_d    = lost_q;
    step      = ripple_step(acc_value, base_q);
    do_step   = (state_q == ST_TRACK) && acc_valid && (acc_value != base_q);
    hs        = (pend_q != '0) && delta_ready;
    pend_base = hs ? '0 : pend_q;
    pend_sum  = {1'b0, pend_base} + (DELTA_W + 1)'(step);
    total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(step);

    if (clear) begin
      state_d = ST_INIT;
      total_d = '0;
      ovf_d   = 1'b0;
      pend_d  = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (acc_valid) begin
            base_d  = acc_value;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (do_step) begin
            base_d  = acc_value;
            total_d = total_sum[TOTAL_W-1:0];
            if (total_sum[TOTAL_W]) ovf_d = 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase

      // A step landing on a handshake cycle starts the new pending value.
      pend_d = pend_base;
      if (do_step) begin
        if (pend_sum > {1'b0, DELTA_MAX}) begin
          pend_d = DELTA_MAX;
          lost_d = 1'b1;
        end else begin
          pend_d = pend_sum[DELTA_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      base_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
    end
  end

  assign total       = total_q;
  assign overflow    = ovf_q;
  assign delta       = pend_q;
  assign delta_valid = (pend_q != '0);
  assign delta_lost  = lost_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor; a TOTAL_W=4 copy covers wrap/overflow.
module tb_ripple_count_monitor;
  import ripple_count_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        delta_ready;
  logic [0:3]  count_in;

  logic [15:0] total;
  logic        overflow, delta_valid, delta_lost;
  logic [4:0]  delta;
  logic [3:0]  total4;
  logic        overflow4, delta_valid4, delta_lost4;
  logic [4:0]  delta4;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int hs0;

  always #5 clk = ~clk;

  ripple_count_monitor #(.TOTAL_W(16), .STABLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .clear(clear),
    .total(total), .overflow(overflow), .delta_valid(delta_valid),
    .delta_ready(delta_ready), .delta(delta), .delta_lost(delta_lost)
  );

  ripple_count_monitor #(.TOTAL_W(4), .STABLE_CYC(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .clear(clear),
    .total(total4), .overflow(overflow4), .delta_valid(delta_valid4),
    .delta_ready(delta_ready), .delta(delta4), .delta_lost(delta_lost4)
  );

  always @(negedge clk)
    if (rst_n && !clear && delta_valid && delta_ready) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [3:0] v, input int hold);
    count_in = v;
    tick(hold);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    rst_n = 1'b1; clear = 1'b0; delta_ready = 1'b0; count_in = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_total", 32'(total), 0);
    chk("rst_valid", 32'(delta_valid), 0);
    chk("rst_delta", 32'(delta), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_lost", 32'(delta_lost), 0);
    tick(2);
    rst_n = 1'b1;

    // baseline 5, then 5 -> 9
    tick(10);
    chk("base_total", 32'(total), 0);
    chk("base_valid", 32'(delta_valid), 0);
    set_cnt(4'd9, 8);
    chk("t27_total", 32'(total), 4);
    chk("t27_delta", 32'(delta), 4);
    chk("t27_valid", 32'(delta_valid), 1);
    tick(3);
    chk("t27_hold_delta", 32'(delta), 4);
    chk("t27_hold_valid", 32'(delta_valid), 1);
    delta_ready = 1'b1;
    tick(1);
    delta_ready = 1'b0;
    chk("t27_hs_valid", 32'(delta_valid), 0);
    chk("t27_hs_total", 32'(total), 4);

    // wrap 14 -> 15 -> 0 -> 1 -> 2 with ready held
    delta_ready = 1'b1;
    pulse_clear();
    chk("clr_total", 32'(total), 0);
    set_cnt(4'd14, 8);
    chk("t28_base_total", 32'(total), 0);
    hs0 = hs_cnt;
    set_cnt(4'd15, 8);
    set_cnt(4'd0, 8);
    set_cnt(4'd1, 8);
    set_cnt(4'd2, 8);
    chk("t28_total", 32'(total), 4);
    chk("t28_hs", 32'(hs_cnt - hs0), 4);
    chk("t28_ovf", 32'(overflow), 0);
    chk("t28_valid", 32'(delta_valid), 0);

    // glitch 7 -> 6 -> 4 -> 8
    pulse_clear();
    set_cnt(4'd7, 8);
    chk("t29_base_total", 32'(total), 0);
    set_cnt(4'd6, 1);
    set_cnt(4'd4, 1);
    set_cnt(4'd8, 8);
    chk("t29_total", 32'(total), 1);

    // handshake and step on the same edge
    delta_ready = 1'b0;
    set_cnt(4'd10, 8);
    chk("merge_pre_delta", 32'(delta), 2);
    count_in = 4'd13;
    tick(4);
    delta_ready = 1'b1;
    tick(1);
    chk("merge_delta", 32'(delta), 3);
    chk("merge_valid", 32'(delta_valid), 1);
    tick(1);
    chk("merge_drain", 32'(delta_valid), 0);
    delta_ready = 1'b0;
    chk("merge_total", 32'(total), 6);

    // saturation: 40 events in steps of 4, ready low
    pulse_clear();
    set_cnt(4'd0, 8);
    for (int i = 1; i <= 10; i++) begin
      v = 4'((i * 4) % 16);
      set_cnt(v, 6);
    end
    chk("t30_total", 32'(total), 40);
    chk("t30_delta", 32'(delta), 31);
    chk("t30_lost", 32'(delta_lost), 1);
    chk("t30_valid", 32'(delta_valid), 1);
    delta_ready = 1'b1;
    tick(1);
    delta_ready = 1'b0;
    chk("t30_hs_valid", 32'(delta_valid), 0);
    chk("t30_lost_sticky", 32'(delta_lost), 1);

    // 17 events into a 4-bit total, then clear racing a step
    pulse_clear();
    chk("clr_lost", 32'(delta_lost), 0);
    set_cnt(4'd12, 8);
    set_cnt(4'd0, 6);
    set_cnt(4'd4, 6);
    set_cnt(4'd8, 6);
    set_cnt(4'd12, 6);
    set_cnt(4'd13, 8);
    chk("t31_total4", 32'(total4), 1);
    chk("t31_ovf4", 32'(overflow4), 1);
    chk("t31_total16", 32'(total), 17);
    chk("t31_ovf16", 32'(overflow), 0);
    count_in = 4'd1;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t31_clr_total", 32'(total), 0);
    chk("t31_clr_total4", 32'(total4), 0);
    chk("t31_clr_ovf4", 32'(overflow4), 0);
    chk("t31_clr_valid", 32'(delta_valid), 0);
    chk("t31_state", 32'(dut.state_q), 32'(ST_INIT));
    set_cnt(4'd3, 8);
    chk("t31_rebase_total", 32'(total), 0);
    chk("t31_rebase_state", 32'(dut.state_q), 32'(ST_TRACK));

    // reset mid-pending
    set_cnt(4'd6, 8);
    chk("t32_pre_delta", 32'(delta), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t32_rst_total", 32'(total), 0);
    chk("t32_rst_delta", 32'(delta), 0);
    chk("t32_rst_valid", 32'(delta_valid), 0);
    chk("t32_rst_lost", 32'(delta_lost), 0);
    chk("t32_rst_ovf", 32'(overflow), 0);
    tick(1);
    rst_n = 1'b1;
    hs0 = hs_cnt;
    delta_ready = 1'b1;
    tick(12);
    chk("t32_no_hs", 32'(hs_cnt - hs0), 0);
    chk("t32_base_total", 32'(total), 0);
    set_cnt(4'd9, 8);
    chk("t32_total", 32'(total), 3);
    chk("t32_hs", 32'(hs_cnt - hs0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
